// File: rtl/redmule_w_buffer_ctrl.sv
// W-buffer sequencer: fills ROWS rows from the W streamer, then replays
// the (elm, col) read-address stream reps times toward the systolic W columns.
module redmule_w_buffer_ctrl #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned ELMS = 2,
    parameter int unsigned REPW = 16,
    localparam int unsigned RAW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CAW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned EAW = (ELMS > 1) ? $clog2(ELMS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [REPW-1:0]     reps_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic                write_en_o,
    output logic [RAW-1:0]      write_addr_o,
    input  logic                rd_ready_i,
    output logic                read_en_o,
    output logic [EAW-1:0]      elms_read_addr_o,
    output logic [CAW-1:0]      cols_read_offs_o,
    output logic [ROWS*RAW-1:0] rows_read_addr_o,
    output logic                rdata_valid_o,
    output logic                busy_o,
    output logic                done_o
);

    // The engine's systolic W columns assume a square array.
    if (ROWS != COLS) begin : g_bad_geometry
        $error("redmule_w_buffer_ctrl: ROWS must equal COLS");
    end

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [RAW-1:0]  wr_row_q, wr_row_d;
    logic [CAW-1:0]  col_q, col_d;
    logic [EAW-1:0]  elm_q, elm_d;
    logic [REPW-1:0] pass_q, pass_d;
    logic [REPW-1:0] reps_q, reps_d;
    logic            rvalid_q, rvalid_d;
    logic            done_q, done_d;

    logic last_row, last_col, last_elm, last_pass;

    assign last_row  = (wr_row_q == RAW'(ROWS - 1));
    assign last_col  = (col_q == CAW'(COLS - 1));
    assign last_elm  = (elm_q == EAW'(ELMS - 1));
    assign last_pass = (pass_q == reps_q - REPW'(1));

    // Handshake and strobes; a clear cycle suppresses any SCM access.
    assign in_ready_o       = (state_q == FILL) && !clear_i;
    assign write_en_o       = in_valid_i && in_ready_o;
    assign write_addr_o     = wr_row_q;
    assign read_en_o        = (state_q == DRAIN) && rd_ready_i && !clear_i;
    assign elms_read_addr_o = elm_q;
    assign cols_read_offs_o = col_q;
    assign rdata_valid_o    = rvalid_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;

    // Every engine row sources from its own SCM row.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
        assign rows_read_addr_o[gi*RAW +: RAW] = RAW'(gi);
    end

    // Next-state logic: fill counter, drain (col, elm, pass) counters, completion.
    always_comb begin
        state_d  = state_q;
        wr_row_d = wr_row_q;
        col_d    = col_q;
        elm_d    = elm_q;
        pass_d   = pass_q;
        reps_d   = reps_q;
        rvalid_d = read_en_o;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    reps_d  = (reps_i == '0) ? REPW'(1) : reps_i;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (write_en_o) begin
                    if (last_row) begin
                        wr_row_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_row_d = wr_row_q + RAW'(1);
                    end
                end
            end
            DRAIN: begin
                if (read_en_o) begin
                    if (!last_col) begin
                        col_d = col_q + CAW'(1);
                    end else begin
                        col_d = '0;
                        if (!last_elm) begin
                            elm_d = elm_q + EAW'(1);
                        end else begin
                            elm_d = '0;
                            if (!last_pass) begin
                                pass_d = pass_q + REPW'(1);
                            end else begin
                                pass_d  = '0;
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d  = IDLE;
            wr_row_d = '0;
            col_d    = '0;
            elm_d    = '0;
            pass_d   = '0;
            reps_d   = '0;
            rvalid_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    // State and counter registers; done is registered to line up with the last rdata.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_row_q <= '0;
            col_q    <= '0;
            elm_q    <= '0;
            pass_q   <= '0;
            reps_q   <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_row_q <= wr_row_d;
            col_q    <= col_d;
            elm_q    <= elm_d;
            pass_q   <= pass_d;
            reps_q   <= reps_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

endmodule
